// File: rtl/interface_circuit_multibyte.sv
// interface_circuit_multibyte: assembles multi-word A/opcode/B frames from UART rx, commits them to the ALU and returns the result word by word.
module interface_circuit_multibyte #(
  parameter int WIDTH_WORD             = 8,
  parameter int CANT_DATOS_ENTRADA_ALU = 16,
  parameter int CANT_BITS_OPCODE_ALU   = 8,
  parameter int CANT_DATOS_SALIDA_ALU  = 16,
  parameter int TIMEOUT_CYCLES         = 100000
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic [WIDTH_WORD-1:0]             i_data_rx,
  input  logic                              i_rx_done,
  input  logic                              i_tx_done,
  input  logic [CANT_DATOS_SALIDA_ALU-1:0]  i_resultado_alu,
  output logic                              o_tx_start,
  output logic [WIDTH_WORD-1:0]             o_data_tx,
  output logic [CANT_DATOS_ENTRADA_ALU-1:0] o_reg_dato_A,
  output logic [CANT_DATOS_ENTRADA_ALU-1:0] o_reg_dato_B,
  output logic [CANT_BITS_OPCODE_ALU-1:0]   o_reg_opcode,
  output logic                              o_busy,
  output logic                              o_error
);
  localparam int W       = WIDTH_WORD;
  localparam int NW_OP   = (CANT_DATOS_ENTRADA_ALU + W - 1) / W;
  localparam int NW_CODE = (CANT_BITS_OPCODE_ALU + W - 1) / W;
  localparam int NW_RES  = (CANT_DATOS_SALIDA_ALU + W - 1) / W;
  localparam int RW      = NW_RES * W;
  localparam int CW      = 8;
  localparam int TW      = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {ESPERA, OPERANDO1, OPERACION, OPERANDO2, CALCULO, TRANSMITE, ESPERA_TX} state_t;

  state_t                state, next_f;
  logic                  prev_rx, prev_tx, rx_evt, tx_evt, last, timeout;
  logic [CW-1:0]         wcnt, tcnt, lim;
  logic [TW-1:0]         to_cnt;
  logic [NW_OP*W-1:0]    sh_a, sh_b, a_nx, b_nx;
  logic [NW_CODE*W-1:0]  sh_c, c_nx;
  logic [RW-1:0]         res, res_in;

  assign rx_evt = i_rx_done & ~prev_rx;
  assign tx_evt = i_tx_done & ~prev_tx;
  assign res_in = RW'(i_resultado_alu);
  assign o_busy = state == CALCULO || state == TRANSMITE || state == ESPERA_TX;

  always_comb begin
    a_nx = sh_a;
    b_nx = sh_b;
    c_nx = sh_c;
    a_nx[wcnt*W +: W] = i_data_rx;
    b_nx[wcnt*W +: W] = i_data_rx;
    c_nx[wcnt*W +: W] = i_data_rx;
    lim = state == OPERACION ? CW'(NW_CODE - 1) : CW'(NW_OP - 1);
    last = wcnt == lim;
    next_f = (state == ESPERA || state == OPERANDO1) ? OPERACION : state == OPERACION ? OPERANDO2 : CALCULO;
    timeout = TIMEOUT_CYCLES != 0 && to_cnt == TW'(TIMEOUT_CYCLES - 1);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state        <= ESPERA;
      prev_rx      <= 1'b0;
      prev_tx      <= 1'b0;
      wcnt         <= '0;
      tcnt         <= '0;
      to_cnt       <= '0;
      sh_a         <= '0;
      sh_b         <= '0;
      sh_c         <= '0;
      res          <= '0;
      o_tx_start   <= 1'b0;
      o_data_tx    <= '0;
      o_reg_dato_A <= '0;
      o_reg_dato_B <= '0;
      o_reg_opcode <= '0;
      o_error      <= 1'b0;
    end else begin
      prev_rx    <= i_rx_done;
      prev_tx    <= i_tx_done;
      o_tx_start <= 1'b0;
      o_error    <= 1'b0;
      case (state)
        ESPERA, OPERANDO1, OPERACION, OPERANDO2: begin
          if (rx_evt) begin
            to_cnt <= '0;
            if (state == ESPERA || state == OPERANDO1) sh_a <= a_nx;
            if (state == OPERACION) sh_c <= c_nx;
            if (state == OPERANDO2) sh_b <= b_nx;
            wcnt  <= last ? '0 : wcnt + 1'b1;
            state <= last ? next_f : state == ESPERA ? OPERANDO1 : state;
            if (last && state == OPERANDO2) begin
              o_reg_dato_A <= sh_a[CANT_DATOS_ENTRADA_ALU-1:0];
              o_reg_dato_B <= b_nx[CANT_DATOS_ENTRADA_ALU-1:0];
              o_reg_opcode <= sh_c[CANT_BITS_OPCODE_ALU-1:0];
            end
          end else if (state != ESPERA) begin
            // an idle frame is dropped whole; committed outputs are untouched
            if (timeout) begin
              state   <= ESPERA;
              sh_a    <= '0;
              sh_b    <= '0;
              sh_c    <= '0;
              wcnt    <= '0;
              to_cnt  <= '0;
              o_error <= 1'b1;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        end
        CALCULO: begin
          res        <= res_in;
          o_data_tx  <= res_in[W-1:0];
          tcnt       <= '0;
          o_tx_start <= 1'b1;
          state      <= ESPERA_TX;
        end
        ESPERA_TX: begin
          if (tx_evt) begin
            if (tcnt == CW'(NW_RES - 1)) begin
              state <= ESPERA;
            end else begin
              tcnt       <= tcnt + 1'b1;
              o_data_tx  <= res[(tcnt + 1'b1)*W +: W];
              o_tx_start <= 1'b1;
            end
          end
        end
        default: state <= ESPERA;
      endcase
    end
  end
endmodule
